uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame-level controller that sequences the UART receiver (`UART_rs232_rx`) in the LED test design. It enables the receiver, detects completed bytes, and parses the byte stream into checksummed command frames. It forwards valid commands to the downstream LED/command logic with a valid/ready handshake and applies its own receiver configuration (`NBits`). Detected faults (framing, length, checksum, inter-byte timeout) are reported as one-cycle pulses.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 160: Tick strobes allowed between bytes inside a frame (10 bit times at 16x) before abort; 8-bit counter, legal range 1..255.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Rst`  in  1  synchronous, active-high reset.
- `En`  in  1  controller enable; when low, `RxEn` is low and the FSM is held in IDLE.
- `Tick`  in  1  baud 16x strobe, one `Clk` cycle wide, `Clk`-synchronous.
- `RxDone`  in  1  receiver byte-done level, asynchronous to `Clk`.
- `RxData`  in  8  receiver output byte; stable from the falling edge of `RxDone`.
- `RxEn`  out  1  receiver enable.
- `NBits`  out  4  receiver data-bit count.
- `CmdValid`  out  1  command available; held until accepted.
- `CmdReady`  in  1  downstream accepts the command.
- `CmdCode`  out  8  command code.
- `CmdLen`  out  3  payload length, 0..4.
- `CmdData`  out  32  payload; byte 0 in [7:0]; unused bytes 0.
- `ErrChk`, `ErrLen`, `ErrTimeout`  out  1 each  one-cycle error pulses.

## Operation
- Byte strobe: `RxDone` passes through a 2-flop synchronizer, then a third flop. `ByteStb` = falling edge of the synchronized `RxDone`. `RxData` is sampled in the `ByteStb` cycle.
- Frame format: `SYNC_BYTE`, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- FSM states and transitions:
  - IDLE: on `ByteStb` with data == `SYNC_BYTE`, go to CMD. Any other byte is discarded silently.
  - CMD: on `ByteStb`, store the code and clear the running XOR to the code; go to LEN.
  - LEN: on `ByteStb`:
    - If LEN > 4: pulse `ErrLen` and go to IDLE.
    - Otherwise store LEN and XOR it in. Go to DATA if LEN > 0, else CHK.
  - DATA: on each `ByteStb`, write the byte at index `idx` (3-bit counter) and XOR it in. After byte LEN−1, go to CHK.
  - CHK: on `ByteStb`:
    - Mismatch: pulse `ErrChk` and go to IDLE.
    - Match with CMD == 8'h0F (config): if payload[0][3:0] is 6, 7 or 8, update `NBits`; otherwise leave it unchanged. No `CmdValid`. Go to IDLE.
    - Match, any other CMD: load the Cmd* outputs and go to HOLD.
  - HOLD: `CmdValid` = 1. When `CmdValid & CmdReady`, go to IDLE.
- Payload register is cleared on entry to CMD.
- `RxEn` = `En` & (state != HOLD). The receiver is stalled while a command is pending, so no bytes are lost to overrun.
- Timeout: an 8-bit counter is cleared on every `ByteStb` and on entry to CMD. In CMD, LEN, DATA and CHK it increments per `Tick`. On reaching `TIMEOUT_TICKS`, pulse `ErrTimeout` and go to IDLE. The counter is inactive in IDLE and HOLD.
- `En` low forces the FSM to IDLE from any state except HOLD, and discards the partial frame. A pending command in HOLD still completes its handshake.

## Timing
- Reset values: state IDLE, `RxEn` 0, `NBits` 4'd8, `CmdValid` 0, `CmdCode` 0, `CmdLen` 0, `CmdData` 0, all Err* 0, counters 0.
- `ByteStb` occurs 3 `Clk` cycles after the falling edge of `RxDone` at the input.
- `CmdValid` rises in the cycle after the CHK `ByteStb`. Cmd* outputs are stable while `CmdValid` is high.
- Accept cycle (`CmdValid` & `CmdReady`): `CmdValid` drops next cycle; `RxEn` rises next cycle (if `En`).
- Err* pulses are registered, one cycle wide, and asserted in the cycle after the triggering `ByteStb` or timeout; the FSM is in IDLE in that same cycle.
- `NBits` updates in the cycle after the config CHK `ByteStb`.
- A `Tick` and a `ByteStb` in the same cycle: the byte wins and the counter is cleared.
- Timeout reached and `ByteStb` in the same cycle: the byte is processed and no timeout is raised.
- `Rst` mid-frame or in HOLD: everything returns to reset values next cycle, including `NBits` = 8.

## Test plan
- Nominal: bytes A5, 01, 02, 3C, C3, then CHK = 01^02^3C^C3 = FC -> `CmdValid`=1, `CmdCode`=01, `CmdLen`=2, `CmdData`=32'h0000C33C. Hold `CmdReady`=0 for 20 cycles -> `CmdValid` and `RxEn`=0 held; assert `CmdReady` -> IDLE, `RxEn`=1.
- Checksum: A5, 01, 01, 55, CHK 00 (correct value 55) -> single `ErrChk` pulse, no `CmdValid`. A following good frame is accepted.
- Length and junk: bytes 12, 34, then A5, 07, 05 -> junk ignored; `ErrLen` pulse after LEN; FSM in IDLE.
- Timeout: A5, 02, then silence, with `TIMEOUT_TICKS`=160 -> `ErrTimeout` exactly at Tick 160 after the last byte. Repeat with the next byte arriving at Tick 159 -> no error.
- Config: A5, 0F, 01, 07, CHK 09 -> `NBits`=7, no `CmdValid`. Same frame with payload 05 (CHK 0B) -> `NBits` unchanged.
- Reset/enable: `Rst` pulse in DATA and in HOLD -> all outputs at reset values next cycle. `En` low mid-frame -> `RxEn`=0, partial frame dropped.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller for the UART receiver: turns the byte stream into checksummed
// command frames (SYNC, CMD, LEN, payload, CHK) and hands them downstream via valid/ready.
module uart_rx_frame_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 160,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        Tick,
  input  logic        RxDone,
  input  logic [7:0]  RxData,
  output logic        RxEn,
  output logic [3:0]  NBits,
  output logic        CmdValid,
  input  logic        CmdReady,
  output logic [7:0]  CmdCode,
  output logic [2:0]  CmdLen,
  output logic [31:0] CmdData,
  output logic        ErrChk,
  output logic        ErrLen,
  output logic        ErrTimeout
);

  typedef enum logic [2:0] {StIdle, StCmd, StLen, StData, StChk, StHold} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] CfgCmd      = 8'h0F;

  state_e      r_state;
  logic [2:0]  r_rxdone_sync;
  logic        r_en;
  logic [7:0]  r_code;
  logic [7:0]  r_xor;
  logic [7:0]  r_tcnt;
  logic [2:0]  r_len;
  logic [2:0]  r_idx;
  logic [31:0] r_payload;
  logic [3:0]  r_nbits;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_code;
  logic [2:0]  r_cmd_len;
  logic [31:0] r_cmd_data;
  logic        r_err_chk;
  logic        r_err_len;
  logic        r_err_to;

  logic        w_byte_stb;
  logic        w_active;
  logic        w_timeout;
  logic [3:0]  w_cfg_bits;

  // [0],[1] synchronize RxDone; [2] is the extra flop for falling-edge detection
  assign w_byte_stb = r_rxdone_sync[2] & ~r_rxdone_sync[1];
  assign w_active   = (r_state != StIdle) && (r_state != StHold);
  assign w_timeout  = Tick && (r_tcnt == TimeoutLast);
  assign w_cfg_bits = r_payload[3:0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= StIdle;
      r_rxdone_sync <= '0;
      r_en          <= 1'b0;
      r_code        <= '0;
      r_xor         <= '0;
      r_tcnt        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_payload     <= '0;
      r_nbits       <= 4'd8;
      r_cmd_valid   <= 1'b0;
      r_cmd_code    <= '0;
      r_cmd_len     <= '0;
      r_cmd_data    <= '0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_to      <= 1'b0;
    end else begin
      r_rxdone_sync <= {r_rxdone_sync[1:0], RxDone};
      r_en          <= En;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_to      <= 1'b0;

      if (w_byte_stb) begin
        r_tcnt <= '0;
      end else if (w_active && Tick) begin
        r_tcnt <= r_tcnt + 8'd1;
      end

      case (r_state)
        StIdle: begin
          if (En && w_byte_stb && (RxData == SYNC_BYTE)) begin
            r_payload <= '0;
            r_state   <= StCmd;
          end
        end
        StHold: begin
          if (CmdReady) begin
            r_cmd_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          // A received byte takes priority over a timeout landing in the same cycle
          if (!En) begin
            r_state <= StIdle;
          end else if (w_byte_stb) begin
            case (r_state)
              StCmd: begin
                r_code  <= RxData;
                r_xor   <= RxData;
                r_state <= StLen;
              end
              StLen: begin
                if (RxData > 8'd4) begin
                  r_err_len <= 1'b1;
                  r_state   <= StIdle;
                end else begin
                  r_len   <= RxData[2:0];
                  r_xor   <= r_xor ^ RxData;
                  r_idx   <= '0;
                  r_state <= (RxData[2:0] == 3'd0) ? StChk : StData;
                end
              end
              StData: begin
                r_payload[{r_idx[1:0], 3'b000} +: 8] <= RxData;
                r_xor <= r_xor ^ RxData;
                r_idx <= r_idx + 3'd1;
                if (r_idx == r_len - 3'd1) begin
                  r_state <= StChk;
                end
              end
              StChk: begin
                if (RxData != r_xor) begin
                  r_err_chk <= 1'b1;
                  r_state   <= StIdle;
                end else if (r_code == CfgCmd) begin
                  if (w_cfg_bits inside {4'd6, 4'd7, 4'd8}) begin
                    r_nbits <= w_cfg_bits;
                  end
                  r_state <= StIdle;
                end else begin
                  r_cmd_valid <= 1'b1;
                  r_cmd_code  <= r_code;
                  r_cmd_len   <= r_len;
                  r_cmd_data  <= r_payload;
                  r_state     <= StHold;
                end
              end
              default: r_state <= StIdle;
            endcase
          end else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_state  <= StIdle;
          end
        end
      endcase
    end
  end

  // Receiver stays stalled while a command waits, so no byte can overrun it
  assign RxEn       = r_en & (r_state != StHold);
  assign NBits      = r_nbits;
  assign CmdValid   = r_cmd_valid;
  assign CmdCode    = r_cmd_code;
  assign CmdLen     = r_cmd_len;
  assign CmdData    = r_cmd_data;
  assign ErrChk     = r_err_chk;
  assign ErrLen     = r_err_len;
  assign ErrTimeout = r_err_to;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: byte-level frame model checked every cycle, plus
// hand-computed literal expectations at key points of a directed sequence.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned TimeoutTicks = 160;
  localparam logic [7:0]  SyncByte     = 8'hA5;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        En = 1'b0;
  logic        Tick = 1'b0;
  logic        RxDone = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        CmdReady = 1'b0;
  logic        RxEn;
  logic [3:0]  NBits;
  logic        CmdValid;
  logic [7:0]  CmdCode;
  logic [2:0]  CmdLen;
  logic [31:0] CmdData;
  logic        ErrChk;
  logic        ErrLen;
  logic        ErrTimeout;

  uart_rx_frame_ctrl #(
    .TIMEOUT_TICKS(TimeoutTicks),
    .SYNC_BYTE    (SyncByte)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .En        (En),
    .Tick      (Tick),
    .RxDone    (RxDone),
    .RxData    (RxData),
    .RxEn      (RxEn),
    .NBits     (NBits),
    .CmdValid  (CmdValid),
    .CmdReady  (CmdReady),
    .CmdCode   (CmdCode),
    .CmdLen    (CmdLen),
    .CmdData   (CmdData),
    .ErrChk    (ErrChk),
    .ErrLen    (ErrLen),
    .ErrTimeout(ErrTimeout)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } pend_t;
  pend_t pend[$];

  // Model: the frame collected so far, pending command, config, expected pulses
  logic [7:0]  frame[$];
  int          m_ticks = 0;
  bit          m_en_q = 1'b0;
  bit          m_hold = 1'b0;
  logic [3:0]  m_nbits = 4'd8;
  logic [7:0]  m_code = 8'h00;
  logic [2:0]  m_len = 3'd0;
  logic [31:0] m_data = 32'h0;
  bit          e_chk = 1'b0;
  bit          e_len = 1'b0;
  bit          e_to = 1'b0;
  bit          cmp_en = 1'b0;
  int          n_chk = 0;
  int          n_len = 0;
  int          n_to = 0;
  bit          tick_en = 1'b0;
  int          tick_ph = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void take_byte(input logic [7:0] b);
    logic [7:0] x;
    int n;
    frame.push_back(b);
    n = frame.size();
    if (n == 3 && b > 8'd4) begin
      e_len = 1'b1;
      frame.delete();
    end else if (n >= 4 && n == 4 + int'(frame[2])) begin
      x = 8'h00;
      for (int i = 1; i < n - 1; i++) x ^= frame[i];
      if (x != b) begin
        e_chk = 1'b1;
      end else if (frame[1] == 8'h0F) begin
        if (n > 4 && frame[3][3:0] >= 4'd6 && frame[3][3:0] <= 4'd8) m_nbits = frame[3][3:0];
      end else begin
        m_hold = 1'b1;
        m_code = frame[1];
        m_len  = frame[2][2:0];
        m_data = 32'h0;
        for (int i = 0; i < n - 4; i++) m_data[8*i +: 8] = frame[3+i];
      end
      frame.delete();
    end
  endfunction

  always @(posedge Clk) begin : model
    pend_t      p;
    bit         stb;
    logic [7:0] b;
    cyc++;
    e_chk = 1'b0;
    e_len = 1'b0;
    e_to  = 1'b0;
    stb   = 1'b0;
    b     = 8'h00;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p   = pend.pop_front();
      stb = 1'b1;
      b   = p.data;
    end
    if (Rst) begin
      frame.delete();
      pend.delete();
      m_ticks = 0;
      m_en_q  = 1'b0;
      m_hold  = 1'b0;
      m_nbits = 4'd8;
      m_code  = 8'h00;
      m_len   = 3'd0;
      m_data  = 32'h0;
    end else begin
      if (m_hold) begin
        if (CmdReady) m_hold = 1'b0;
      end else if (frame.size() != 0) begin
        if (!En) begin
          frame.delete();
        end else if (stb) begin
          m_ticks = 0;
          take_byte(b);
        end else if (Tick) begin
          m_ticks++;
          if (m_ticks == int'(TimeoutTicks)) begin
            e_to = 1'b1;
            frame.delete();
          end
        end
      end else if (En && stb && b == SyncByte) begin
        frame.push_back(b);
        m_ticks = 0;
      end
      m_en_q = En;
    end
    cmp_en = 1'b1;
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      cmp("rxen", 32'(RxEn), 32'(m_en_q && !m_hold));
      cmp("nbits", 32'(NBits), 32'(m_nbits));
      cmp("cmd_valid", 32'(CmdValid), 32'(m_hold));
      cmp("err_chk", 32'(ErrChk), 32'(e_chk));
      cmp("err_len", 32'(ErrLen), 32'(e_len));
      cmp("err_timeout", 32'(ErrTimeout), 32'(e_to));
      if (m_hold) begin
        cmp("cmd_code", 32'(CmdCode), 32'(m_code));
        cmp("cmd_len", 32'(CmdLen), 32'(m_len));
        cmp("cmd_data", CmdData, m_data);
      end
      if (ErrChk) n_chk++;
      if (ErrLen) n_len++;
      if (ErrTimeout) n_to++;
    end
  end

  always begin
    @(posedge Clk);
    #1;
    if (tick_en) begin
      Tick    = (tick_ph == 2);
      tick_ph = (tick_ph + 1) % 3;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks_off();
    tick_en = 1'b0;
    step();
    Tick = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tick_at_stb);
    int c;
    RxData = b;
    RxDone = 1'b1;
    repeat (4) step();
    RxDone = 1'b0;
    c = cyc;
    pend.push_back('{c + 3, b});
    step();
    step();
    if (tick_at_stb) Tick = 1'b1;
    step();
    if (tick_at_stb) Tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      Tick = 1'b1;
      step();
      Tick = 1'b0;
      step();
    end
  endtask

  task automatic accept(input int wait_cycles);
    repeat (wait_cycles) step();
    CmdReady = 1'b1;
    step();
    CmdReady = 1'b0;
    cmp("accept_valid_low", 32'(CmdValid), 32'd0);
    cmp("accept_rxen_high", 32'(RxEn), 32'd1);
  endtask

  initial begin
    repeat (2) step();
    cmp("rst_nbits", 32'(NBits), 32'd8);
    cmp("rst_rxen", 32'(RxEn), 32'd0);
    cmp("rst_valid", 32'(CmdValid), 32'd0);
    cmp("rst_code", 32'(CmdCode), 32'd0);
    cmp("rst_len", 32'(CmdLen), 32'd0);
    cmp("rst_data", CmdData, 32'd0);
    cmp("rst_errs", 32'({ErrChk, ErrLen, ErrTimeout}), 32'd0);
    Rst     = 1'b0;
    En      = 1'b1;
    tick_en = 1'b1;
    repeat (3) step();
    cmp("en_rxen", 32'(RxEn), 32'd1);

    // Nominal frame, then a long stall before acceptance
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h3C, 8'hC3, 8'hFC});
    cmp("nom_valid", 32'(CmdValid), 32'd1);
    cmp("nom_code", 32'(CmdCode), 32'h01);
    cmp("nom_len", 32'(CmdLen), 32'd2);
    cmp("nom_data", CmdData, 32'h0000C33C);
    cmp("nom_rxen_stall", 32'(RxEn), 32'd0);
    repeat (20) step();
    cmp("nom_valid_held", 32'(CmdValid), 32'd1);
    cmp("nom_rxen_held", 32'(RxEn), 32'd0);
    accept(0);

    // Bad checksum, then a full 4-byte payload frame
    send_frame('{8'hA5, 8'h01, 8'h01, 8'h55, 8'h00});
    cmp("chk_no_valid", 32'(CmdValid), 32'd0);
    send_frame('{8'hA5, 8'h10, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h50});
    cmp("full_code", 32'(CmdCode), 32'h10);
    cmp("full_len", 32'(CmdLen), 32'd4);
    cmp("full_data", CmdData, 32'h44332211);
    accept(3);

    // Junk bytes, then an over-long LEN
    send_frame('{8'h12, 8'h34, 8'hA5, 8'h07, 8'h05});
    cmp("len_no_valid", 32'(CmdValid), 32'd0);

    // Config frames: legal width then ignored width
    send_frame('{8'hA5, 8'h0F, 8'h01, 8'h07, 8'h09});
    cmp("cfg_nbits7", 32'(NBits), 32'd7);
    cmp("cfg_no_valid", 32'(CmdValid), 32'd0);
    send_frame('{8'hA5, 8'h0F, 8'h01, 8'h05, 8'h0B});
    cmp("cfg_nbits_kept", 32'(NBits), 32'd7);

    // Reset in the middle of the payload
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h3C});
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    cmp("rst_data_nbits", 32'(NBits), 32'd8);
    cmp("rst_data_rxen", 32'(RxEn), 32'd0);
    cmp("rst_data_code", 32'(CmdCode), 32'd0);
    cmp("rst_data_len", 32'(CmdLen), 32'd0);
    cmp("rst_data_data", CmdData, 32'd0);
    repeat (2) step();

    // Reset while a command is pending
    send_frame('{8'hA5, 8'h03, 8'h01, 8'hAA, 8'hA8});
    cmp("hold_valid", 32'(CmdValid), 32'd1);
    cmp("hold_data", CmdData, 32'h000000AA);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    cmp("rst_hold_valid", 32'(CmdValid), 32'd0);
    cmp("rst_hold_code", 32'(CmdCode), 32'd0);
    cmp("rst_hold_data", CmdData, 32'd0);
    cmp("rst_hold_rxen", 32'(RxEn), 32'd0);
    repeat (2) step();

    // Inter-byte timeout: 159 ticks are tolerated, the 160th aborts
    ticks_off();
    send_frame('{8'hA5, 8'h02});
    pulse_ticks(159);
    cmp("to_not_yet", 32'(ErrTimeout), 32'd0);
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    cmp("to_pulse", 32'(ErrTimeout), 32'd1);
    step();
    cmp("to_pulse_end", 32'(ErrTimeout), 32'd0);

    // Next byte after 159 ticks keeps the frame alive
    send_frame('{8'hA5, 8'h02});
    pulse_ticks(159);
    send_frame('{8'h00, 8'h02});
    cmp("to159_valid", 32'(CmdValid), 32'd1);
    cmp("to159_code", 32'(CmdCode), 32'h02);
    cmp("to159_len", 32'(CmdLen), 32'd0);
    accept(2);

    // 160th tick coincides with the byte strobe: the byte wins
    send_frame('{8'hA5, 8'h02});
    pulse_ticks(159);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b0);
    cmp("tie_valid", 32'(CmdValid), 32'd1);
    accept(1);

    // Enable dropped mid-frame: the partial frame is discarded
    tick_en = 1'b1;
    send_frame('{8'hA5, 8'h03});
    En = 1'b0;
    repeat (2) step();
    cmp("en_low_rxen", 32'(RxEn), 32'd0);
    repeat (3) step();
    En = 1'b1;
    repeat (2) step();
    send_frame('{8'h00, 8'h03});
    cmp("en_drop_no_valid", 32'(CmdValid), 32'd0);
    repeat (3) step();

    cmp("count_err_chk", 32'(n_chk), 32'd1);
    cmp("count_err_len", 32'(n_len), 32'd1);
    cmp("count_err_timeout", 32'(n_to), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
